// File: rtl/alu_loader_pkg.sv
// -----------------------------------------------------------------------------
// alu_loader_pkg
//   Shared definitions for the ALU operand loader: collector state encoding,
//   byte positions within a 5-byte operand frame, SEL field positions and the
//   SEL reserved-bit check.
// -----------------------------------------------------------------------------
package alu_loader_pkg;

  // Collector state: gathering bytes, or holding a complete shadow frame.
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } state_t;

  localparam int FRAME_BYTES = 5;
  localparam int IDX_W       = 3;

  // Byte order within a frame as it arrives on the stream.
  localparam logic [IDX_W-1:0] IDX_A0  = 3'd0;
  localparam logic [IDX_W-1:0] IDX_B0  = 3'd1;
  localparam logic [IDX_W-1:0] IDX_A1  = 3'd2;
  localparam logic [IDX_W-1:0] IDX_B1  = 3'd3;
  localparam logic [IDX_W-1:0] IDX_SEL = 3'd4;

  // SEL byte layout: [1:0] unit-1 select, [3:2] unit-2 select, [7:4] reserved.
  localparam int SEL1_LSB    = 0;
  localparam int SEL2_LSB    = 2;
  localparam int SEL_RSV_LSB = 4;

  // A SEL byte is acceptable when checking is off or its reserved nibble is zero.
  function automatic logic sel_ok(input logic [7:0] sel, input logic check);
    return !check || (sel[7:SEL_RSV_LSB] == 4'h0);
  endfunction

endpackage

// File: rtl/alu_operand_loader.sv
// -----------------------------------------------------------------------------
// alu_operand_loader
//   Assembles 5-byte operand frames (A0, B0, A1, B1, SEL) from a byte stream
//   into a shadow frame, then commits complete frames into a single-entry
//   output slot feeding the dual 8-bit ALU stage. Collection of the next frame
//   overlaps the frame held at the ALU.
//
// Ports
//   wb_clk_i    : clock, rising edge
//   wb_rst_ni   : asynchronous active-low reset
//   in_data_i   : stream byte          in_valid_i : byte valid
//   in_ready_o  : byte accepted this cycle when in_valid_i is high
//   in_abort_i  : discard the partial/complete shadow frame
//   A0_o..B1_o  : operands for ALU unit 1 (A0,B0) and unit 2 (A1,B1)
//   ALU_Sel1_o  : unit-1 select (SEL[1:0])   ALU_Sel2_o : unit-2 select (SEL[3:2])
//   op_valid_o  : output slot holds a frame  op_ready_i : ALU consumes the slot
//   err_o       : 1-cycle pulse, frame dropped on SEL reserved-bit check
//   busy_o      : partial or complete shadow frame present
//   frames_o    : committed-frame count, wraps
// -----------------------------------------------------------------------------
module alu_operand_loader
  import alu_loader_pkg::*;
#(
  parameter int FCNT_W    = 16,
  parameter bit SEL_CHECK = 1'b1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_abort_i,
  output logic [7:0]        A0_o,
  output logic [7:0]        B0_o,
  output logic [7:0]        A1_o,
  output logic [7:0]        B1_o,
  output logic [1:0]        ALU_Sel1_o,
  output logic [1:0]        ALU_Sel2_o,
  output logic              op_valid_o,
  input  logic              op_ready_i,
  output logic              err_o,
  output logic              busy_o,
  output logic [FCNT_W-1:0] frames_o
);

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [7:0]       shadow_reg [FRAME_BYTES];
  logic             err_reg;
  logic             run_reg;

  logic [7:0]        a0_reg, b0_reg, a1_reg, b1_reg;
  logic [1:0]        sel1_reg, sel2_reg;
  logic              op_valid_reg;
  logic [FCNT_W-1:0] frames_reg;

  logic accept;
  logic slot_free;
  logic commit;

  // run_reg keeps in_ready_o low while in reset and for the release cycle,
  // so the interface reports "not ready" until the first clock edge.
  assign in_ready_o = run_reg && (state_reg == ST_COLLECT) && !in_abort_i;
  assign accept     = in_valid_i && in_ready_o;
  // The slot may be refilled in the same cycle the ALU consumes it.
  assign slot_free  = !op_valid_reg || op_ready_i;
  // Abort has priority over a pending commit.
  assign commit     = (state_reg == ST_FULL) && slot_free && !in_abort_i;

  // Collector: byte index, state, shadow frame and SEL-check error pulse.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg <= ST_COLLECT;
      idx_reg   <= IDX_A0;
      err_reg   <= 1'b0;
      run_reg   <= 1'b0;
      for (int i = 0; i < FRAME_BYTES; i++) begin
        shadow_reg[i] <= 8'h00;
      end
    end else begin
      run_reg <= 1'b1;
      err_reg <= 1'b0;
      if (in_abort_i) begin
        state_reg <= ST_COLLECT;
        idx_reg   <= IDX_A0;
      end else if (accept) begin
        shadow_reg[idx_reg] <= in_data_i;
        if (idx_reg == IDX_SEL) begin
          idx_reg <= IDX_A0;
          if (sel_ok(in_data_i, SEL_CHECK)) begin
            state_reg <= ST_FULL;
          end else begin
            err_reg <= 1'b1;
          end
        end else begin
          idx_reg <= idx_reg + 3'd1;
        end
      end else if (commit) begin
        state_reg <= ST_COLLECT;
      end
    end
  end

  // Output slot and committed-frame counter.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      a0_reg       <= 8'h00;
      b0_reg       <= 8'h00;
      a1_reg       <= 8'h00;
      b1_reg       <= 8'h00;
      sel1_reg     <= 2'b00;
      sel2_reg     <= 2'b00;
      op_valid_reg <= 1'b0;
      frames_reg   <= '0;
    end else if (commit) begin
      a0_reg       <= shadow_reg[IDX_A0];
      b0_reg       <= shadow_reg[IDX_B0];
      a1_reg       <= shadow_reg[IDX_A1];
      b1_reg       <= shadow_reg[IDX_B1];
      sel1_reg     <= shadow_reg[IDX_SEL][SEL1_LSB +: 2];
      sel2_reg     <= shadow_reg[IDX_SEL][SEL2_LSB +: 2];
      op_valid_reg <= 1'b1;
      frames_reg   <= frames_reg + 1'b1;
    end else if (op_ready_i) begin
      // Consumed with nothing to refill: operands keep their last value.
      op_valid_reg <= 1'b0;
    end
  end

  assign A0_o       = a0_reg;
  assign B0_o       = b0_reg;
  assign A1_o       = a1_reg;
  assign B1_o       = b1_reg;
  assign ALU_Sel1_o = sel1_reg;
  assign ALU_Sel2_o = sel2_reg;
  assign op_valid_o = op_valid_reg;
  assign frames_o   = frames_reg;
  assign err_o      = err_reg;
  assign busy_o     = (idx_reg != IDX_A0) || (state_reg == ST_FULL);

endmodule

// File: tb/tb_alu_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_loader
//   Directed bench for alu_operand_loader. Counter width is reduced to 4 bits
//   so the counter wrap is reached within a short run.
// -----------------------------------------------------------------------------
module tb_alu_operand_loader;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_abort;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] sel1, sel2;
  logic       op_valid;
  logic       op_ready;
  logic       err;
  logic       busy;
  logic [3:0] frames;

  int tests_run = 0;
  int tests_failed = 0;

  alu_operand_loader #(.FCNT_W(4), .SEL_CHECK(1'b1)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_abort_i (in_abort),
    .A0_o       (a0),
    .B0_o       (b0),
    .A1_o       (a1),
    .B1_o       (b1),
    .ALU_Sel1_o (sel1),
    .ALU_Sel2_o (sel2),
    .op_valid_o (op_valid),
    .op_ready_i (op_ready),
    .err_o      (err),
    .busy_o     (busy),
    .frames_o   (frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; checks follow that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    $display("[TB] byte 0x%02h sent t=%0t", b, $time);
  endtask

  task automatic send_frame(input logic [7:0] x0, input logic [7:0] y0,
                            input logic [7:0] x1, input logic [7:0] y1,
                            input logic [7:0] s);
    send(x0); send(y0); send(x1); send(y1); send(s);
  endtask

  task automatic check_ops(input string tag, input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] x1, input logic [7:0] y1,
                           input logic [1:0] s1, input logic [1:0] s2);
    check({tag, "_a0"}, 32'(a0), 32'(x0));
    check({tag, "_b0"}, 32'(b0), 32'(y0));
    check({tag, "_a1"}, 32'(a1), 32'(x1));
    check({tag, "_b1"}, 32'(b1), 32'(y1));
    check({tag, "_sel1"}, 32'(sel1), 32'(s1));
    check({tag, "_sel2"}, 32'(sel2), 32'(s2));
  endtask

  initial begin
    rst_n    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_abort = 1'b0;
    op_ready = 1'b1;

    // ---- Reset state ----
    #12;
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frames", 32'(frames), 32'd0);
    check_ops("rst", 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // ---- 1: basic frame, op_ready=1 ----
    send_frame(8'h12, 8'h34, 8'h56, 8'h78, 8'h05);
    check("t1_opv_at_sel", 32'(op_valid), 32'd0);
    check("t1_busy_full", 32'(busy), 32'd1);
    tick();
    check("t1_opv", 32'(op_valid), 32'd1);
    check_ops("t1", 8'h12, 8'h34, 8'h56, 8'h78, 2'd1, 2'd1);
    check("t1_frames", 32'(frames), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    $display("[TB] test1 frame committed t=%0t", $time);

    // ---- 2: backpressure, second frame waits in shadow ----
    op_ready = 1'b0;
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h0E);
    tick();
    check("t2_in_ready_full", 32'(in_ready), 32'd0);
    check("t2_opv_hold", 32'(op_valid), 32'd1);
    check_ops("t2_hold", 8'h12, 8'h34, 8'h56, 8'h78, 2'd1, 2'd1);
    check("t2_frames_hold", 32'(frames), 32'd1);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check_ops("t2", 8'h11, 8'h22, 8'h33, 8'h44, 2'd2, 2'd3);
    check("t2_frames", 32'(frames), 32'd2);
    check("t2_in_ready", 32'(in_ready), 32'd1);
    check("t2_opv", 32'(op_valid), 32'd1);
    $display("[TB] test2 backpressured frame committed t=%0t", $time);

    // ---- 3: SEL reserved bits set -> dropped ----
    send_frame(8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h15);
    check("t3_err", 32'(err), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_frames", 32'(frames), 32'd2);
    check("t3_opv", 32'(op_valid), 32'd1);
    tick();
    check("t3_err_pulse", 32'(err), 32'd0);
    check("t3_frames2", 32'(frames), 32'd2);
    check_ops("t3", 8'h11, 8'h22, 8'h33, 8'h44, 2'd2, 2'd3);
    $display("[TB] test3 bad SEL dropped t=%0t", $time);

    // ---- 4: abort with in_valid same cycle ----
    send(8'h01); send(8'h02); send(8'h03);
    check("t4_busy_partial", 32'(busy), 32'd1);
    in_abort = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    check("t4_in_ready_abort", 32'(in_ready), 32'd0);
    tick();
    in_abort = 1'b0;
    in_valid = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    op_ready = 1'b1;
    send_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h09);
    tick();
    check_ops("t4", 8'hAA, 8'hBB, 8'hCC, 8'hDD, 2'd1, 2'd2);
    check("t4_frames", 32'(frames), 32'd3);
    $display("[TB] test4 abort then clean frame t=%0t", $time);

    // ---- 5: counter wrap (4-bit counter) ----
    for (int i = 0; i < 12; i++) begin
      send_frame(8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3), 8'h00);
      tick();
    end
    check("t5_frames_max", 32'(frames), 32'hF);
    send_frame(8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h0B);
    tick();
    check("t5_frames_wrap", 32'(frames), 32'h0);
    check("t5_opv", 32'(op_valid), 32'd1);
    check_ops("t5", 8'h5A, 8'h6B, 8'h7C, 8'h8D, 2'd3, 2'd2);
    $display("[TB] test5 counter wrapped t=%0t", $time);

    // ---- 6: asynchronous reset mid-frame ----
    op_ready = 1'b0;
    send(8'h21); send(8'h22);
    check("t6_busy_pre", 32'(busy), 32'd1);
    check("t6_opv_pre", 32'(op_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_opv", 32'(op_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_frames", 32'(frames), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    check_ops("t6", 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0);
    $display("[TB] test6 async reset cleared outputs t=%0t", $time);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
